melody_sequencer: RTL and testbench
===================================

MELODY_SEQUENCER -- requirements
Module: melody_sequencer

Interface
REQ-001 Parameter BEAT_CYCLES, default 12500000, clkin cycles per duration unit (0.25 s at 50 MHz).
REQ-002 Parameter GAP_CYCLES, default 500000, silent clkin cycles inserted after every note.
REQ-003 clkin  in  1  sole clock; all logic on posedge clkin.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 start  in  1  level; sampled only in IDLE, begins playback at address 0.
REQ-006 pause  in  1  level; freezes playback while high.
REQ-007 rom_addr  out  4  note ROM address.
REQ-008 rom_data  in  8  ROM word: [7:4] note code, [3:0] duration in beats; valid one cycle after rom_addr.
REQ-009 divn  out  32  period, in clkin cycles, for the downstream programmable tone divider.
REQ-010 tone_en  out  1  high while the divider shall sound.
REQ-011 busy  out  1  high in every state except IDLE.
REQ-012 done  out  1  one-cycle pulse on song completion.

Function
REQ-013 States SHALL be IDLE, FETCH, LOAD, PLAY, GAP, DONE.
- IDLE -> FETCH on start=1, with rom_addr=0.
- FETCH -> LOAD after exactly 1 cycle.
- LOAD latches rom_data; if duration=0, go to DONE (end marker), else go to PLAY.
- PLAY -> GAP after duration*BEAT_CYCLES unpaused cycles.
- GAP -> FETCH with rom_addr+1 after GAP_CYCLES unpaused cycles.
- DONE -> IDLE after 1 cycle.
REQ-014 GAP ending at rom_addr=15 SHALL go to DONE instead of FETCH (no wrap).
REQ-015 divn SHALL be decoded in LOAD from the note code:
- 1 = 191113, 2 = 170265, 3 = 151685, 4 = 143171, 5 = 127551, 6 = 113636, 7 = 101239, 8 = 95556 (C4..C5 at 50 MHz).
- 0 and 9-15 are rests: divn is held and tone_en stays 0 for that note.
REQ-016 tone_en SHALL be 1 exactly during unpaused PLAY cycles of non-rest notes, and 0 in all other states.
REQ-017 divn SHALL hold its last value in GAP, DONE and IDLE.
REQ-018 The duration product SHALL be computed at 32 bits; BEAT_CYCLES*15 must fit in 32 bits.
REQ-019 pause=1 in PLAY or GAP SHALL freeze the cycle counter and state and force tone_en=0; playback resumes at the same count when pause falls.
REQ-020 pause SHALL have no effect in IDLE, FETCH, LOAD or DONE.
REQ-021 start while busy=1 SHALL be ignored.
REQ-022 done SHALL be 1 only in the DONE cycle.

Reset
REQ-023 reset SHALL take priority over all inputs and may occur mid-operation.
REQ-024 The cycle after reset is sampled, the block SHALL be in IDLE with rom_addr=0, divn=0, tone_en=0, busy=0, done=0, counters=0.

Configuration
REQ-025 Macro SEQ_LOOP_EN:
- When defined: an end marker or the end of address 15 SHALL go to FETCH at rom_addr=0 instead of DONE, and done SHALL never pulse; only reset stops playback.
- When undefined: behaviour is per REQ-013 and REQ-014.

Verification (BEAT_CYCLES=4, GAP_CYCLES=2)
REQ-026 ROM[0]=0x12, ROM[1]=0x00; pulse start -> FETCH, LOAD, then tone_en=1 for 8 cycles with divn=191113, 2 gap cycles, FETCH, LOAD, done pulse 1 cycle, busy=0.
REQ-027 ROM[0]=0x01, ROM[1]=0x61, ROM[2]=0x00 -> first note: tone_en=0 for 4 cycles and divn held; second note: divn=113636 and tone_en=1 for 4 cycles.
REQ-028 ROM all 0x81 -> 16 notes of 4 tone cycles each, then done after address 15; rom_addr never wraps.
REQ-029 pause=1 for 5 cycles mid-PLAY of 0x52 -> tone_en=0 during pause; total tone_en-high cycles still 8; GAP starts 5 cycles late.
REQ-030 reset asserted during GAP of address 3 -> next cycle IDLE with all outputs at reset values; start replays from address 0.
REQ-031 SEQ_LOOP_EN defined, ROM[0]=0x31, ROM[1]=0x00 -> rom_addr sequence 0,1,0,1,...; done stays 0 for 100 cycles.

Source files
------------

// File: rtl/melody_sequencer_if.sv
// melody_sequencer_if: groups the control, note ROM and tone-divider signals
// of the melody sequencer. The master modport is the sequencer itself; the
// slave modport is the surrounding system (controller, ROM, tone divider).
interface melody_sequencer_if;
    logic        start;
    logic        pause;
    logic [3:0]  rom_addr;
    logic [7:0]  rom_data;
    logic [31:0] divn;
    logic        tone_en;
    logic        busy;
    logic        done;

    modport master (
        input  start,
        input  pause,
        input  rom_data,
        output rom_addr,
        output divn,
        output tone_en,
        output busy,
        output done
    );

    modport slave (
        output start,
        output pause,
        output rom_data,
        input  rom_addr,
        input  divn,
        input  tone_en,
        input  busy,
        input  done
    );
endinterface

// File: rtl/melody_sequencer.sv
// melody_sequencer: steps through a 16-entry note ROM and drives the period
// and enable of a downstream programmable tone divider.
//
// Each ROM word is {note_code[3:0], beats[3:0]}. A word with beats=0 is the
// end marker. Every note sounds for beats*BEAT_CYCLES clocks and is followed
// by GAP_CYCLES silent clocks. Note codes 1..8 select C4..C5; any other code
// is a rest (divn held, tone stays off).
//
// Optional build macro SEQ_LOOP_EN: when defined, the end marker and the end
// of address 15 restart the song at address 0 instead of finishing, and done
// never pulses. Without it the song plays once and ends with a done pulse.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for start; outputs hold, busy=0
// S_FETCH | rom_addr presented to the ROM, data arrives next cycle
// S_LOAD  | ROM word latched: decode period, load note timer or finish
// S_PLAY  | note sounding; timer counts down while not paused
// S_GAP   | silent gap after a note; timer counts down while not paused
// S_DONE  | one-cycle song-complete pulse, then back to idle
module melody_sequencer #(
    parameter int unsigned BEAT_CYCLES = 12500000,
    parameter int unsigned GAP_CYCLES  = 500000
) (
    input  logic               clkin,
    input  logic               reset,
    melody_sequencer_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_PLAY  = 3'd3,
        S_GAP   = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    // Beat length kept at 32 bits so beats*BEAT_CYCLES never truncates below
    // the full 32-bit range. A zero gap length skips the gap state entirely.
    localparam logic [31:0] BEAT_LEN = 32'(BEAT_CYCLES);
    localparam logic [31:0] GAP_LEN  = 32'(GAP_CYCLES);
    localparam bit          HAS_GAP  = (GAP_CYCLES != 0);
    localparam logic [3:0]  LAST_ADDR = 4'd15;

    state_t      state_q,  state_nxt;
    logic [3:0]  addr_q,   addr_nxt;
    logic [31:0] divn_q,   divn_nxt;
    logic [31:0] cnt_q,    cnt_nxt;
    logic        rest_q,   rest_nxt;

    logic [3:0]  note_code;
    logic [3:0]  note_beats;
    logic [32:0] note_lookup;
    logic        note_hit;
    logic [31:0] note_period;
    logic [31:0] play_len;
    logic        timer_run;
    logic        timer_tc;

    // Song-position step taken when a note (and its gap) has finished, or
    // when the end marker is seen: next fetch address or end of song.
    state_t      end_state;
    logic [3:0]  end_addr;
    state_t      step_state;
    logic [3:0]  step_addr;

    // Period lookup: bit 32 flags a sounding note, bits 31:0 are the
    // divider period in clkin cycles (50 MHz reference).
    function automatic logic [32:0] note_lookup_f(input logic [3:0] code);
        logic [32:0] r;
        case (code)
            4'd1:    r = {1'b1, 32'd191113};
            4'd2:    r = {1'b1, 32'd170265};
            4'd3:    r = {1'b1, 32'd151685};
            4'd4:    r = {1'b1, 32'd143171};
            4'd5:    r = {1'b1, 32'd127551};
            4'd6:    r = {1'b1, 32'd113636};
            4'd7:    r = {1'b1, 32'd101239};
            4'd8:    r = {1'b1, 32'd95556};
            default: r = 33'd0;
        endcase
        return r;
    endfunction

    // ROM word split, note decode and note length.
    always_comb begin
        note_code   = bus.rom_data[7:4];
        note_beats  = bus.rom_data[3:0];
        note_lookup = note_lookup_f(note_code);
        note_hit    = note_lookup[32];
        note_period = note_lookup[31:0];
        play_len    = 32'(note_beats) * BEAT_LEN;
    end

    // Timer enable and terminal count; pause only freezes the timed states.
    always_comb begin
        timer_run = ((state_q == S_PLAY) || (state_q == S_GAP)) && !bus.pause;
        timer_tc  = (cnt_q == 32'd0);
    end

    // Where the song goes when it runs out (end marker or past address 15).
    always_comb begin
`ifdef SEQ_LOOP_EN
        end_state = S_FETCH;
        end_addr  = 4'd0;
`else
        end_state = S_DONE;
        end_addr  = addr_q;
`endif
    end

    // Where the song goes after a note and its gap have completed.
    always_comb begin
        if (addr_q == LAST_ADDR) begin
            step_state = end_state;
            step_addr  = end_addr;
        end else begin
            step_state = S_FETCH;
            step_addr  = addr_q + 4'd1;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_nxt = state_q;
        addr_nxt  = addr_q;
        divn_nxt  = divn_q;
        cnt_nxt   = cnt_q;
        rest_nxt  = rest_q;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_nxt = S_FETCH;
                    addr_nxt  = 4'd0;
                end
            end

            S_FETCH: begin
                state_nxt = S_LOAD;
            end

            S_LOAD: begin
                if (note_beats == 4'd0) begin
                    state_nxt = end_state;
                    addr_nxt  = end_addr;
                    cnt_nxt   = 32'd0;
                end else begin
                    state_nxt = S_PLAY;
                    cnt_nxt   = play_len - 32'd1;
                    rest_nxt  = !note_hit;
                    if (note_hit) begin
                        divn_nxt = note_period;
                    end
                end
            end

            S_PLAY: begin
                if (timer_run) begin
                    if (!timer_tc) begin
                        cnt_nxt = cnt_q - 32'd1;
                    end else if (HAS_GAP) begin
                        state_nxt = S_GAP;
                        cnt_nxt   = GAP_LEN - 32'd1;
                    end else begin
                        state_nxt = step_state;
                        addr_nxt  = step_addr;
                        cnt_nxt   = 32'd0;
                    end
                end
            end

            S_GAP: begin
                if (timer_run) begin
                    if (!timer_tc) begin
                        cnt_nxt = cnt_q - 32'd1;
                    end else begin
                        state_nxt = step_state;
                        addr_nxt  = step_addr;
                        cnt_nxt   = 32'd0;
                    end
                end
            end

            S_DONE: begin
                state_nxt = S_IDLE;
            end

            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = 32'd0;
            end
        endcase
    end

    // State and datapath registers; reset wins over every other input.
    always_ff @(posedge clkin) begin
        if (reset) begin
            state_q <= S_IDLE;
            addr_q  <= 4'd0;
            divn_q  <= 32'd0;
            cnt_q   <= 32'd0;
            rest_q  <= 1'b0;
        end else begin
            state_q <= state_nxt;
            addr_q  <= addr_nxt;
            divn_q  <= divn_nxt;
            cnt_q   <= cnt_nxt;
            rest_q  <= rest_nxt;
        end
    end

    // Outputs: tone only on unpaused play cycles of a real note.
    always_comb begin
        bus.rom_addr = addr_q;
        bus.divn     = divn_q;
        bus.tone_en  = (state_q == S_PLAY) && !bus.pause && !rest_q;
        bus.busy     = (state_q != S_IDLE);
        bus.done     = (state_q == S_DONE);
    end

endmodule

// File: tb/tb_melody_sequencer.sv
// tb_melody_sequencer: directed scoreboard bench for melody_sequencer with
// BEAT_CYCLES=4, GAP_CYCLES=2. The monitor cuts the output stream into one
// record per ROM address visited (cycles spent, tone cycles, final divn,
// whether it ended in a done pulse) and checks each against the queue of
// hand-computed records pushed by the stimulus.
module tb_melody_sequencer;

    localparam int unsigned BEAT = 4;
    localparam int unsigned GAP  = 2;

    logic clkin = 1'b0;
    logic reset = 1'b1;

    melody_sequencer_if bus ();

    melody_sequencer #(
        .BEAT_CYCLES (BEAT),
        .GAP_CYCLES  (GAP)
    ) dut (
        .clkin (clkin),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clkin = ~clkin;

    // Synchronous note ROM: data valid the cycle after the address.
    logic [7:0] rom [16];
    always @(posedge clkin) bus.rom_data <= rom[bus.rom_addr];

    typedef struct {
        logic [3:0]  addr;
        int          cycles;
        int          tones;
        logic [31:0] divn;
        logic        done;
    } rec_t;

    rec_t exp_q[$];
    int   total = 0;
    int   bad   = 0;
    int   done_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input logic [3:0] a, input int c, input int t,
                        input logic [31:0] d, input logic dn);
        rec_t r;
        r.addr = a; r.cycles = c; r.tones = t; r.divn = d; r.done = dn;
        exp_q.push_back(r);
    endtask

    // Monitor: segment accumulation and scoreboard compare.
    logic        seg_open = 1'b0;
    rec_t        seg;

    task automatic emit(input logic dn);
        rec_t e;
        seg.done = dn;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_record: got addr %0d cycles %0d, expected none",
                     seg.addr, seg.cycles);
        end else begin
            e = exp_q.pop_front();
            chk($sformatf("a%0d_addr", e.addr),   32'(seg.addr), 32'(e.addr));
            chk($sformatf("a%0d_cycles", e.addr), seg.cycles,    e.cycles);
            chk($sformatf("a%0d_tones", e.addr),  seg.tones,     e.tones);
            chk($sformatf("a%0d_divn", e.addr),   seg.divn,      e.divn);
            chk($sformatf("a%0d_done", e.addr),   32'(seg.done), 32'(e.done));
        end
        seg_open = 1'b0;
    endtask

    always @(negedge clkin) begin
        if (bus.done === 1'b1) done_cnt++;
        if (seg_open && (bus.busy !== 1'b1 || bus.rom_addr != seg.addr)) emit(1'b0);
        if (!seg_open && bus.busy === 1'b1) begin
            seg_open   = 1'b1;
            seg.addr   = bus.rom_addr;
            seg.cycles = 0;
            seg.tones  = 0;
        end
        if (seg_open) begin
            seg.cycles++;
            if (bus.tone_en === 1'b1) seg.tones++;
            seg.divn = bus.divn;
            if (bus.done === 1'b1) emit(1'b1);
        end
    end

    task automatic tick();
        @(posedge clkin);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        chk("rst_rom_addr", 32'(bus.rom_addr), 32'd0);
        chk("rst_divn",     bus.divn,          32'd0);
        chk("rst_tone_en",  32'(bus.tone_en),  32'd0);
        chk("rst_busy",     32'(bus.busy),     32'd0);
        chk("rst_done",     32'(bus.done),     32'd0);
        reset = 1'b0;
        tick();
        tick();
        done_cnt = 0;
    endtask

    task automatic set_rom(input logic [7:0] fill);
        for (int i = 0; i < 16; i++) rom[i] = fill;
    endtask

    task automatic pulse_start(input int n);
        bus.start = 1'b1;
        repeat (n) tick();
        bus.start = 1'b0;
    endtask

    task automatic drain(input string name, input int budget, input int exp_done);
        int n = 0;
        while ((exp_q.size() != 0 || bus.busy === 1'b1) && n < budget) begin
            tick();
            n++;
        end
        tick();
        tick();
        chk({name, "_pending"}, 32'(exp_q.size()), 32'd0);
        chk({name, "_dones"},   32'(done_cnt),     32'(exp_done));
        exp_q.delete();
    endtask

    initial begin
        bus.start = 1'b0;
        bus.pause = 1'b0;
        set_rom(8'h00);
        do_reset();

`ifdef SEQ_LOOP_EN
        // Looping song: 0,1,0,1,... for 100 cycles, never done.
        set_rom(8'h00);
        rom[0] = 8'h31;
        for (int k = 0; k < 10; k++) begin
            push(4'd0, 8, 4, 32'd151685, 1'b0);
            push(4'd1, 2, 0, 32'd151685, 1'b0);
        end
        pulse_start(1);
        repeat (99) tick();
        do_reset();
        chk("loop_pending", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
`else
        // One note then end marker.
        set_rom(8'h00);
        rom[0] = 8'h12;
        push(4'd0, 12, 8, 32'd191113, 1'b0);
        push(4'd1, 3,  0, 32'd191113, 1'b1);
        pulse_start(1);
        drain("t1", 200, 1);

        // Rest then real note; start held while busy must be ignored.
        do_reset();
        rom[0] = 8'h01; rom[1] = 8'h61; rom[2] = 8'h00;
        push(4'd0, 8, 0, 32'd0,      1'b0);
        push(4'd1, 8, 4, 32'd113636, 1'b0);
        push(4'd2, 3, 0, 32'd113636, 1'b1);
        pulse_start(6);
        drain("t2", 200, 1);

        // Full ROM of notes: ends after address 15 without wrapping.
        do_reset();
        set_rom(8'h81);
        for (int i = 0; i < 15; i++) push(4'(i), 8, 4, 32'd95556, 1'b0);
        push(4'd15, 9, 4, 32'd95556, 1'b1);
        pulse_start(1);
        drain("t3", 400, 1);

        // Pause for 5 cycles in the middle of a 2-beat note.
        do_reset();
        set_rom(8'h00);
        rom[0] = 8'h52;
        push(4'd0, 17, 8, 32'd127551, 1'b0);
        push(4'd1, 3,  0, 32'd127551, 1'b1);
        pulse_start(1);
        repeat (3) tick();
        bus.pause = 1'b1;
        repeat (5) tick();
        bus.pause = 1'b0;
        drain("t4", 200, 1);

        // Reset during the gap of address 3, then replay from address 0.
        do_reset();
        set_rom(8'h81);
        for (int i = 0; i < 3; i++) push(4'(i), 8, 4, 32'd95556, 1'b0);
        push(4'd3, 7, 4, 32'd95556, 1'b0);
        pulse_start(1);
        repeat (30) tick();
        do_reset();
        chk("t5a_pending", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        set_rom(8'h00);
        rom[0] = 8'h12;
        push(4'd0, 12, 8, 32'd191113, 1'b0);
        push(4'd1, 3,  0, 32'd191113, 1'b1);
        pulse_start(1);
        drain("t5b", 200, 1);

        // End marker at address 0: immediate finish, divn untouched.
        do_reset();
        set_rom(8'h00);
        push(4'd0, 3, 0, 32'd0, 1'b1);
        pulse_start(1);
        drain("t6", 100, 1);

        // Non-looping build of the loop song: plays once.
        do_reset();
        rom[0] = 8'h31;
        push(4'd0, 8, 4, 32'd151685, 1'b0);
        push(4'd1, 3, 0, 32'd151685, 1'b1);
        pulse_start(1);
        drain("t7", 200, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
